// File: rtl/me_pkg.sv
// Shared motion-estimation constants and FSM encoding.
// The FIFO-fill and motion-vector stages import this package as well.
package me_pkg;

    localparam int PIX_PER_BLOCK = 16;
    localparam int NUM_CAND      = 49;
    localparam int SAD_W         = 8 + $clog2(PIX_PER_BLOCK);
    localparam int IDX_W         = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } me_state_t;

endpackage

// File: rtl/abs_diff8.sv
// Combinational absolute difference of two 8-bit unsigned pixels.
module abs_diff8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff
);

    assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_block_accumulator.sv
// Pops paired pixels from the current and reference FIFOs, accumulates per-block SAD
// and tracks the best candidate across one search window.
//
// state    | meaning
// ST_IDLE  | waiting for start, strobes low
// ST_RUN   | issuing pixel pairs whenever both FIFOs are non-empty
// ST_FLUSH | last pair issued, waiting for its SAD to retire (done)
module sad_block_accumulator #(
    parameter  int PIX_PER_BLOCK = me_pkg::PIX_PER_BLOCK,
    parameter  int NUM_CAND      = me_pkg::NUM_CAND,
    localparam int SAD_W         = 8 + $clog2(PIX_PER_BLOCK),
    localparam int IDX_W         = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cur_data,
    input  logic             cur_empty,
    output logic             cur_rd,
    input  logic [7:0]       ref_data,
    input  logic             ref_empty,
    output logic             ref_rd,
    output logic             busy,
    output logic [SAD_W-1:0] sad_out,
    output logic             sad_valid,
    output logic [IDX_W-1:0] sad_idx,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             done
);

    import me_pkg::*;

    localparam int               PIX_W     = $clog2(PIX_PER_BLOCK);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    me_state_t        state;
    me_state_t        state_nxt;
    logic             issue;
    logic             start_acc;
    logic [PIX_W-1:0] pix_cnt;
    logic [IDX_W-1:0] cand_cnt;

    logic             r_valid;
    logic             r_pix_first;
    logic             r_pix_last;
    logic             r_cand_last;
    logic [IDX_W-1:0] r_cand;

    logic [7:0]       diff;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] acc_sum;

    abs_diff8 u_abs_diff8 (
        .a    (cur_data),
        .b    (ref_data),
        .diff (diff)
    );

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                issue = !cur_empty && !ref_empty;
                if (issue && pix_cnt == PIX_LAST && cand_cnt == CAND_LAST)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Hold here through the done cycle so busy drops the cycle after.
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start_acc = (state == ST_IDLE) && start;
    assign cur_rd    = issue;
    assign ref_rd    = issue;
    assign busy      = (state != ST_IDLE);
    assign acc_sum   = (r_pix_first ? '0 : acc) + SAD_W'(diff);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt     <= '0;
            cand_cnt    <= '0;
            r_valid     <= 1'b0;
            r_pix_first <= 1'b0;
            r_pix_last  <= 1'b0;
            r_cand_last <= 1'b0;
            r_cand      <= '0;
        end else begin
            // Tags travel one cycle to line up with the FIFO data_out.
            r_valid     <= issue;
            r_pix_first <= (pix_cnt == '0);
            r_pix_last  <= (pix_cnt == PIX_LAST);
            r_cand_last <= (cand_cnt == CAND_LAST);
            r_cand      <= cand_cnt;
            if (start_acc) begin
                pix_cnt  <= '0;
                cand_cnt <= '0;
            end else if (issue) begin
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt  <= '0;
                    cand_cnt <= (cand_cnt == CAND_LAST) ? '0 : cand_cnt + IDX_W'(1);
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            sad_out   <= '0;
            sad_valid <= 1'b0;
            sad_idx   <= '0;
            best_sad  <= '1;
            best_idx  <= '0;
            done      <= 1'b0;
        end else begin
            sad_valid <= 1'b0;
            done      <= 1'b0;
            if (start_acc) begin
                best_sad <= '1;
                best_idx <= '0;
            end
            if (r_valid) begin
                acc <= acc_sum;
                if (r_pix_last) begin
                    sad_out   <= acc_sum;
                    sad_valid <= 1'b1;
                    sad_idx   <= r_cand;
                    done      <= r_cand_last;
                    // Strict compare: on a tie the earlier candidate stays best.
                    if (r_cand == '0 || acc_sum < best_sad) begin
                        best_sad <= acc_sum;
                        best_idx <= r_cand;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Directed bench for sad_block_accumulator: three-candidate searches fed from a FIFO model.
module tb_sad_block_accumulator;

    localparam int PIX = 16;
    localparam int NC  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cur_data = 8'd0;
    logic [7:0]  ref_data = 8'd0;
    logic        cur_empty = 1'b1;
    logic        ref_empty = 1'b1;
    logic        cur_rd, ref_rd, busy, sad_valid, done;
    logic [11:0] sad_out, best_sad;
    logic [1:0]  sad_idx, best_idx;

    always #5 clk = ~clk;

    sad_block_accumulator #(.PIX_PER_BLOCK(PIX), .NUM_CAND(NC)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cur_data  (cur_data),
        .cur_empty (cur_empty),
        .cur_rd    (cur_rd),
        .ref_data  (ref_data),
        .ref_empty (ref_empty),
        .ref_rd    (ref_rd),
        .busy      (busy),
        .sad_out   (sad_out),
        .sad_valid (sad_valid),
        .sad_idx   (sad_idx),
        .best_sad  (best_sad),
        .best_idx  (best_idx),
        .done      (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: data_out registered on pop, empty flag registered
    logic [7:0] cur_q[$];
    logic [7:0] ref_q[$];
    bit         ref_hold = 1'b0;

    always @(posedge clk) begin : fifo_model
        int nc;
        int nr;
        if (rst) begin
            cur_q.delete();
            ref_q.delete();
            cur_empty <= 1'b1;
            ref_empty <= 1'b1;
        end else begin
            nc = cur_q.size();
            nr = ref_q.size();
            if (cur_rd && nc > 0) begin
                cur_data <= cur_q.pop_front();
                nc--;
            end
            if (ref_rd && nr > 0) begin
                ref_data <= ref_q.pop_front();
                nr--;
            end
            cur_empty <= (nc == 0);
            ref_empty <= (nr == 0) || ref_hold;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] sv_sad[$];
    int          sv_idx[$];
    int          sv_cyc[$];
    int          sv_done[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_issue_cyc = 0;
    int          issue_cnt = 0;
    logic [11:0] d_best_sad = 12'd0;
    int          d_best_idx = 0;
    int          d_busy = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_pair", cur_rd, ref_rd);
            check("rd_when_empty", cur_rd & (cur_empty | ref_empty), 0);
            if (cur_rd) begin
                issue_cnt++;
                last_issue_cyc = cyc;
            end
            if (sad_valid) begin
                sv_sad.push_back(sad_out);
                sv_idx.push_back(int'(sad_idx));
                sv_cyc.push_back(cyc);
                sv_done.push_back(int'(done));
            end
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                d_best_sad = best_sad;
                d_best_idx = int'(best_idx);
                d_busy     = int'(busy);
            end
        end
    end

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  r;
        logic [7:0]  r0;
        logic [11:0] sad;
    } vec_t;

    vec_t        vecs[12];
    logic [11:0] exp_best_sad[4];
    int          exp_best_idx[4];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_search(input int s);
        vec_t v;
        sv_sad.delete();
        sv_idx.delete();
        sv_cyc.delete();
        sv_done.delete();
        issue_cnt = 0;
        for (int k = 0; k < NC; k++) begin
            v = vecs[s*NC + k];
            for (int p = 0; p < PIX; p++) begin
                cur_q.push_back(v.c);
                ref_q.push_back((p == 0) ? v.r0 : v.r);
            end
        end
        tick();
        tick();
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n_before);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > n_before) break;
            tick();
        end
        check("done_seen", done_cnt > n_before, 1);
        tick();
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_results(input int s, input bit gaps);
        check("sad_count", sv_sad.size(), NC);
        for (int i = 0; i < NC && i < sv_sad.size(); i++) begin
            check($sformatf("s%0d_sad%0d", s, i), sv_sad[i], vecs[s*NC + i].sad);
            check($sformatf("s%0d_idx%0d", s, i), sv_idx[i], i);
            check($sformatf("s%0d_done%0d", s, i), sv_done[i], (i == NC-1) ? 1 : 0);
            if (gaps && i > 0)
                check($sformatf("s%0d_gap%0d", s, i), sv_cyc[i] - sv_cyc[i-1], PIX);
        end
        check($sformatf("s%0d_best_sad", s), d_best_sad, exp_best_sad[s]);
        check($sformatf("s%0d_best_idx", s), d_best_idx, exp_best_idx[s]);
        check($sformatf("s%0d_busy_at_done", s), d_busy, 1);
        check($sformatf("s%0d_done_latency", s), done_cyc - last_issue_cyc, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        int n0;
        vecs[0]  = '{8'd10,  8'd7,   8'd7,   12'd48};
        vecs[1]  = '{8'd255, 8'd0,   8'd0,   12'd4080};
        vecs[2]  = '{8'd0,   8'd255, 8'd255, 12'd4080};
        vecs[3]  = '{8'd10,  8'd13,  8'd15,  12'd50};
        vecs[4]  = '{8'd10,  8'd11,  8'd15,  12'd20};
        vecs[5]  = '{8'd10,  8'd11,  8'd15,  12'd20};
        vecs[6]  = '{8'd100, 8'd100, 8'd100, 12'd0};
        vecs[7]  = '{8'd200, 8'd73,  8'd73,  12'd2032};
        vecs[8]  = '{8'd50,  8'd50,  8'd60,  12'd10};
        vecs[9]  = '{8'd5,   8'd9,   8'd9,   12'd64};
        vecs[10] = '{8'd9,   8'd9,   8'd0,   12'd9};
        vecs[11] = '{8'd4,   8'd4,   8'd4,   12'd0};
        exp_best_sad = '{12'd48, 12'd20, 12'd0, 12'd0};
        exp_best_idx = '{0, 1, 0, 2};

        repeat (3) tick();
        check("rst_cur_rd", cur_rd, 0);
        check("rst_ref_rd", ref_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_sad_out", sad_out, 0);
        check("rst_sad_valid", sad_valid, 0);
        check("rst_sad_idx", sad_idx, 0);
        check("rst_best_sad", best_sad, 12'hFFF);
        check("rst_best_idx", best_idx, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Search 0: plain run, extremes and swapped operands.
        load_search(0);
        n = done_cnt;
        pulse_start(c0);
        check("s0_busy_first", busy, 1);
        check("s0_rd_first", cur_rd, 1);
        wait_done(n);
        check("s0_done_cycle", done_cyc - c0, 50);
        check_results(0, 1'b1);

        // Search 1: reference FIFO held empty for 5 cycles in candidate 1.
        load_search(1);
        n = done_cnt;
        pulse_start(c0);
        repeat (19) tick();
        ref_hold = 1'b1;
        tick();
        n0 = cur_q.size();
        check("stall_rd_0", cur_rd | ref_rd, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("stall_rd_%0d", i), cur_rd | ref_rd, 0);
        end
        check("stall_cur_count", cur_q.size(), n0);
        ref_hold = 1'b0;
        wait_done(n);
        check("s1_done_cycle", done_cyc - c0, 55);
        check_results(1, 1'b0);

        // Search 2: plain run.
        load_search(2);
        n = done_cnt;
        pulse_start(c0);
        wait_done(n);
        check_results(2, 1'b1);

        // Reset after 8 pixels of candidate 2.
        load_search(1);
        n = done_cnt;
        pulse_start(c0);
        for (int i = 0; i < 200; i++) begin
            if (issue_cnt >= 2*PIX + 8) break;
            tick();
        end
        check("mid_issue_reached", issue_cnt >= 2*PIX + 8, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rd", cur_rd | ref_rd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_best_sad", best_sad, 12'hFFF);
        check("mid_rst_best_idx", best_idx, 0);
        check("mid_rst_sad_valid", sad_valid, 0);
        repeat (10) tick();
        check("mid_rst_sad_count", sv_sad.size(), 2);
        check("mid_rst_no_done", done_cnt, n);
        if (sv_sad.size() >= 2) begin
            check("mid_rst_sad0", sv_sad[0], 12'd50);
            check("mid_rst_sad1", sv_sad[1], 12'd20);
        end

        load_search(2);
        n = done_cnt;
        pulse_start(c0);
        wait_done(n);
        check_results(2, 1'b1);

        // Search 3 with a stray start while busy.
        load_search(3);
        n = done_cnt;
        pulse_start(c0);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("s3_done_cycle", done_cyc - c0, 50);
        check("s3_single_done", done_cnt, n + 1);
        check_results(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
